// File: rtl/cpu_int_ctrl.sv
// Interrupt controller for the 6502-style core: fixed-priority IRQs, edge-triggered NMI, BRK, NMI hijack.
// Optional macro CPU_INT_EDGE_IRQ_EN switches IRQ channels from level to latched falling-edge mode.
module cpu_int_ctrl #(
    parameter int NUM_IRQ = 4,
    parameter int SYNC_FF = 2
) (
    input  logic               clk_ph1,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic               nmi_n,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               i_flag,
    input  logic               poll,
    input  logic               brk,
    input  logic               int_ack,
    input  logic               vec_fetch,
    input  logic [NUM_IRQ-1:0] irq_clr,
    output logic               int_req,
    output logic               b_flag,
    output logic [7:0]         vec_lo,
    output logic [2:0]         src_id,
    output logic [NUM_IRQ-1:0] pending
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SVC  = 2'd2;

    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    logic [SYNC_FF-1:0][NUM_IRQ-1:0] r_irq_sync;
    logic [SYNC_FF-1:0]              r_nmi_sync;
    logic                            r_nmi_prev;
    logic                            r_nmi_lat;
    logic [1:0]                      r_state;
    logic                            r_b_flag;
    logic [7:0]                      r_vec_lo;
    logic [2:0]                      r_src_id;

    logic [NUM_IRQ-1:0] w_irq_s;
    logic               w_nmi_s;
    logic               w_nmi_fall;
    logic               w_irq_hit;
    logic               w_take;
    logic               w_nmi_use;

    function automatic logic [2:0] f_lowest(input logic [NUM_IRQ-1:0] v);
        f_lowest = 3'd0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (v[k]) f_lowest = 3'(k);
        end
    endfunction

    // Synchronisers idle high so reset never looks like a falling edge
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            r_irq_sync <= '1;
            r_nmi_sync <= '1;
        end else begin
            r_irq_sync[0] <= irq_n;
            r_nmi_sync[0] <= nmi_n;
            for (int k = 1; k < SYNC_FF; k++) begin
                r_irq_sync[k] <= r_irq_sync[k-1];
                r_nmi_sync[k] <= r_nmi_sync[k-1];
            end
        end
    end

    assign w_irq_s = r_irq_sync[SYNC_FF-1];
    assign w_nmi_s = r_nmi_sync[SYNC_FF-1];

`ifdef CPU_INT_EDGE_IRQ_EN
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_irq_lat;

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            r_irq_prev <= '1;
            r_irq_lat  <= '0;
        end else begin
            r_irq_prev <= w_irq_s;
            r_irq_lat  <= (r_irq_lat & ~irq_clr) | (r_irq_prev & ~w_irq_s);
        end
    end

    assign pending = r_irq_lat & irq_mask;
`else
    logic w_unused_clr;
    assign w_unused_clr = ^irq_clr;
    assign pending      = ~w_irq_s & irq_mask;
`endif

    assign w_nmi_fall = r_nmi_prev & ~w_nmi_s;
    assign w_irq_hit  = (|pending) & ~i_flag;
    assign w_take     = poll & (r_nmi_lat | w_irq_hit);
    assign w_nmi_use  = (r_state == S_SVC) & vec_fetch & r_nmi_lat;

    // A fresh edge on the consuming cycle must not be lost
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            r_nmi_prev <= 1'b1;
            r_nmi_lat  <= 1'b0;
        end else begin
            r_nmi_prev <= w_nmi_s;
            if (w_nmi_fall)     r_nmi_lat <= 1'b1;
            else if (w_nmi_use) r_nmi_lat <= 1'b0;
        end
    end

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_b_flag <= 1'b1;
            r_vec_lo <= VEC_IRQ;
            r_src_id <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state <= S_REQ;
                        if (!r_nmi_lat) r_src_id <= f_lowest(pending);
                    end else if (brk) begin
                        r_state  <= S_SVC;
                        r_b_flag <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (int_ack) begin
                        r_state  <= S_SVC;
                        r_b_flag <= 1'b0;
                    end
                end
                S_SVC: begin
                    // NMI hijacks the vector of whichever sequence is running
                    if (vec_fetch) begin
                        r_vec_lo <= r_nmi_lat ? VEC_NMI : VEC_IRQ;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign int_req = (r_state == S_REQ);
    assign b_flag  = r_b_flag;
    assign vec_lo  = r_vec_lo;
    assign src_id  = r_src_id;

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Directed table-driven bench for cpu_int_ctrl (NUM_IRQ=4, SYNC_FF=2).
module tb_cpu_int_ctrl;

    logic       clk_ph1 = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq_n = 4'hF;
    logic       nmi_n = 1'b1;
    logic [3:0] irq_mask = 4'hF;
    logic       i_flag = 1'b0;
    logic       poll = 1'b0;
    logic       brk = 1'b0;
    logic       int_ack = 1'b0;
    logic       vec_fetch = 1'b0;
    logic [3:0] irq_clr = 4'h0;
    logic       int_req;
    logic       b_flag;
    logic [7:0] vec_lo;
    logic [2:0] src_id;
    logic [3:0] pending;

    int total = 0;
    int bad = 0;

    cpu_int_ctrl #(.NUM_IRQ(4), .SYNC_FF(2)) dut (
        .clk_ph1(clk_ph1), .rst(rst), .irq_n(irq_n), .nmi_n(nmi_n),
        .irq_mask(irq_mask), .i_flag(i_flag), .poll(poll), .brk(brk),
        .int_ack(int_ack), .vec_fetch(vec_fetch), .irq_clr(irq_clr),
        .int_req(int_req), .b_flag(b_flag), .vec_lo(vec_lo),
        .src_id(src_id), .pending(pending)
    );

    always #5 clk_ph1 = ~clk_ph1;

    typedef struct {
        logic       rst;
        logic [3:0] irq;
        logic       nmi;
        logic [3:0] msk;
        logic       ifl;
        logic       pl;
        logic       bk;
        logic       ak;
        logic       vf;
        logic       e_req;
        logic       e_b;
        logic [7:0] e_vec;
        logic [2:0] e_src;
        logic [3:0] e_pend;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] irq, input logic nmi,
                       input logic [3:0] msk, input logic ifl, input logic pl,
                       input logic bk, input logic ak, input logic vf,
                       input logic er, input logic eb, input logic [7:0] ev,
                       input logic [2:0] es, input logic [3:0] ep);
        vec_t v;
        v.rst = r; v.irq = irq; v.nmi = nmi; v.msk = msk; v.ifl = ifl;
        v.pl = pl; v.bk = bk; v.ak = ak; v.vf = vf;
        v.e_req = er; v.e_b = eb; v.e_vec = ev; v.e_src = es; v.e_pend = ep;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ph1);
        #1;
    endtask

    logic want_ack = 1'b0;
    logic want_vf  = 1'b0;
    int   nmi_seqs = 0;

    // Runs n cycles with nmi_n held low, polling at the two given cycles and answering int_req
    task automatic run_nmi_low(input int n, input int pa, input int pb);
        nmi_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            poll      = (i == pa) || (i == pb);
            int_ack   = want_ack;
            vec_fetch = want_vf;
            tick();
            if (vec_fetch) chk("nmi_run vec_lo", 32'(vec_lo), 32'hFA);
            want_vf  = int_ack;
            want_ack = int_req;
            if (int_req) nmi_seqs++;
        end
        poll = 1'b0; int_ack = 1'b0; vec_fetch = 1'b0;
        want_ack = 1'b0; want_vf = 1'b0;
    endtask

    initial begin
        // rst irq nmi msk if pl bk ak vf | req b vec src pend
        add(0, 4'hF, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(0, 4'hF, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hB, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hB, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h4);
        add(1, 4'hB, 1, 4'hF, 0, 1, 0, 0, 0,  1, 1, 8'hFE, 3'd2, 4'h4);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 1, 0,  0, 0, 8'hFE, 3'd2, 4'h4);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 1,  0, 0, 8'hFE, 3'd2, 4'h0);
        add(1, 4'h6, 1, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFE, 3'd2, 4'h0);
        add(1, 4'h6, 1, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFE, 3'd2, 4'h9);
        add(1, 4'h6, 1, 4'hF, 0, 1, 0, 0, 0,  1, 0, 8'hFE, 3'd0, 4'h9);
        add(1, 4'h6, 1, 4'hF, 0, 0, 0, 1, 0,  0, 0, 8'hFE, 3'd0, 4'h9);
        add(1, 4'h6, 1, 4'hF, 0, 0, 0, 0, 1,  0, 0, 8'hFE, 3'd0, 4'h9);
        add(1, 4'h6, 1, 4'hF, 1, 1, 0, 0, 0,  0, 0, 8'hFE, 3'd0, 4'h9);
        add(1, 4'h6, 1, 4'hF, 1, 0, 0, 0, 0,  0, 0, 8'hFE, 3'd0, 4'h9);
        add(1, 4'h6, 1, 4'h6, 0, 1, 0, 0, 0,  0, 0, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFE, 3'd0, 4'h9);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFE, 3'd0, 4'h0);
        // NMI held low: one sequence only, then re-arm with a rising edge
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 1, 0, 0, 0,  1, 0, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 1, 0,  0, 0, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 1,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 1, 0, 0, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 1, 0, 0, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 1, 0, 0, 0,  1, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 1, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 1,  0, 0, 8'hFA, 3'd0, 4'h0);
        // Plain BRK
        add(1, 4'hF, 1, 4'hF, 0, 0, 1, 0, 0,  0, 1, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 1,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        // IRQ hijacked by NMI between int_ack and vec_fetch
        add(1, 4'hE, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hE, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h1);
        add(1, 4'hE, 1, 4'hF, 0, 1, 0, 0, 0,  1, 1, 8'hFE, 3'd0, 4'h1);
        add(1, 4'hE, 0, 4'hF, 0, 0, 0, 1, 0,  0, 0, 8'hFE, 3'd0, 4'h1);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFE, 3'd0, 4'h1);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 0, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 1,  0, 0, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 1, 0, 0, 0,  0, 0, 8'hFA, 3'd0, 4'h0);
        // BRK hijacked by NMI
        add(1, 4'hF, 1, 4'hF, 0, 0, 1, 0, 0,  0, 1, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 1,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 1, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 0, 0, 0, 1,  0, 1, 8'hFA, 3'd0, 4'h0);
        add(1, 4'hF, 0, 4'hF, 0, 1, 0, 0, 0,  0, 1, 8'hFA, 3'd0, 4'h0);
        // poll and brk together with a pending IRQ: interrupt wins
        add(1, 4'h7, 0, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFA, 3'd0, 4'h0);
        add(1, 4'h7, 0, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFA, 3'd0, 4'h8);
        add(1, 4'h7, 0, 4'hF, 0, 1, 1, 0, 0,  1, 1, 8'hFA, 3'd3, 4'h8);
        add(1, 4'h7, 0, 4'hF, 0, 0, 0, 1, 0,  0, 0, 8'hFA, 3'd3, 4'h8);
        add(1, 4'h7, 0, 4'hF, 0, 0, 0, 0, 1,  0, 0, 8'hFE, 3'd3, 4'h8);
        // Reset while in REQ
        add(1, 4'h7, 1, 4'hF, 0, 1, 0, 0, 0,  1, 0, 8'hFE, 3'd3, 4'h8);
        add(0, 4'h7, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'h7, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h0);
        add(1, 4'h7, 1, 4'hF, 0, 0, 0, 0, 0,  0, 1, 8'hFE, 3'd0, 4'h8);
        add(1, 4'h7, 1, 4'hF, 0, 1, 0, 0, 0,  1, 1, 8'hFE, 3'd3, 4'h8);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 1, 0,  0, 0, 8'hFE, 3'd3, 4'h8);
        add(1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 1,  0, 0, 8'hFE, 3'd3, 4'h0);

`ifndef CPU_INT_EDGE_IRQ_EN
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; irq_n = tbl[i].irq; nmi_n = tbl[i].nmi;
            irq_mask = tbl[i].msk; i_flag = tbl[i].ifl; poll = tbl[i].pl;
            brk = tbl[i].bk; int_ack = tbl[i].ak; vec_fetch = tbl[i].vf;
            tick();
            chk($sformatf("row%0d int_req", i), 32'(int_req), 32'(tbl[i].e_req));
            chk($sformatf("row%0d b_flag", i), 32'(b_flag), 32'(tbl[i].e_b));
            chk($sformatf("row%0d vec_lo", i), 32'(vec_lo), 32'(tbl[i].e_vec));
            chk($sformatf("row%0d src_id", i), 32'(src_id), 32'(tbl[i].e_src));
            chk($sformatf("row%0d pending", i), 32'(pending), 32'(tbl[i].e_pend));
        end
        poll = 1'b0; brk = 1'b0; int_ack = 1'b0; vec_fetch = 1'b0;

        // Level mode ignores irq_clr
        irq_n = 4'hD; irq_clr = 4'h2;
        repeat (3) tick();
        chk("level irq_clr ignored", 32'(pending), 32'h2);
        irq_n = 4'hF; irq_clr = 4'h0;
        repeat (2) tick();
        chk("level release", 32'(pending), 32'h0);
`else
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        irq_n = 4'hD;
        tick();
        irq_n = 4'hF;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("edge hold%0d", i), 32'(pending), 32'h2);
            tick();
        end
        irq_clr = 4'h2;
        tick();
        irq_clr = 4'h0;
        chk("edge cleared", 32'(pending), 32'h0);
        tick();
        chk("edge stays cleared", 32'(pending), 32'h0);
`endif

        // NMI held low for 20 cycles with two polls, then re-armed
        irq_n = 4'hF; nmi_n = 1'b1;
        repeat (3) tick();
        nmi_seqs = 0;
        run_nmi_low(20, 5, 12);
        chk("nmi held low sequences", 32'(nmi_seqs), 32'd1);
        nmi_n = 1'b1;
        repeat (3) tick();
        run_nmi_low(10, 4, 4);
        chk("nmi second edge sequences", 32'(nmi_seqs), 32'd2);
        chk("nmi end int_req", 32'(int_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
